// File: rtl/swg_loop_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// swg_loop_ctrl_pkg
// Shared types and helpers for the SWG nested-loop controller.
//   state_e     : step tag carried on out_state
//   ctrl_e      : IDLE/RUN controller state
//   LEVELS, H/W/KH/KW/SIMD : loop-level indices used to slice the config fields
//   lvl2state   : loop-level index -> step tag
//   order_lvl   : position in the odometer (0 = innermost) -> loop-level index
// -----------------------------------------------------------------------------
package swg_loop_ctrl_pkg;

   typedef enum logic [2:0] {
      STATE_START     = 3'd0,
      STATE_LOOP_SIMD = 3'd1,
      STATE_LOOP_KW   = 3'd2,
      STATE_LOOP_KH   = 3'd3,
      STATE_LOOP_W    = 3'd4,
      STATE_LOOP_H    = 3'd5
   } state_e;

   typedef enum logic {
      CTRL_IDLE = 1'b0,
      CTRL_RUN  = 1'b1
   } ctrl_e;

   localparam int LEVELS = 5;

   // Level indices; also the field index inside cfg_count (H in the MSBs).
   // Inside cfg_incr the level's field sits one slot higher, START is slot 0.
   localparam int H    = 4;
   localparam int W    = 3;
   localparam int KH   = 2;
   localparam int KW   = 1;
   localparam int SIMD = 0;

   function automatic state_e lvl2state(input int lvl);
      case (lvl)
         SIMD:    return STATE_LOOP_SIMD;
         KW:      return STATE_LOOP_KW;
         KH:      return STATE_LOOP_KH;
         W:       return STATE_LOOP_W;
         H:       return STATE_LOOP_H;
         default: return STATE_START;
      endcase
   endfunction

   // Depthwise keeps the kernel window innermost and moves SIMD outside it.
   function automatic int order_lvl(input bit dw, input int pos);
      if (dw) begin
         case (pos)
            0:       return KW;
            1:       return KH;
            2:       return SIMD;
            3:       return W;
            default: return H;
         endcase
      end else begin
         case (pos)
            0:       return SIMD;
            1:       return KW;
            2:       return KH;
            3:       return W;
            default: return H;
         endcase
      end
   endfunction

endpackage

// File: rtl/swg_loop_ctrl_if.sv
// -----------------------------------------------------------------------------
// swg_loop_ctrl_if
// Config and step streams of the SWG loop controller.
//   cfg_valid/cfg_ready : config handshake
//   cfg_count           : {H,W,KH,KW,SIMD} unsigned counts, CNT_BITS each
//   cfg_incr            : {H,W,KH,KW,SIMD,START} signed increments
//   out_valid/out_ready : step handshake
//   out_incr/out_state/out_last : increment, tag and end-of-run flag of a step
// modport master = the controller, modport slave = config source / consumer.
// -----------------------------------------------------------------------------
interface swg_loop_ctrl_if
   import swg_loop_ctrl_pkg::*;
#(
   parameter int CNT_BITS  = 16,
   parameter int INCR_BITS = 16
) ();

   logic                     cfg_valid;
   logic                     cfg_ready;
   logic [5*CNT_BITS-1:0]    cfg_count;
   logic [6*INCR_BITS-1:0]   cfg_incr;

   logic                     out_valid;
   logic                     out_ready;
   logic [INCR_BITS-1:0]     out_incr;
   state_e                   out_state;
   logic                     out_last;

   modport master (
      input  cfg_valid, cfg_count, cfg_incr, out_ready,
      output cfg_ready, out_valid, out_incr, out_state, out_last
   );

   modport slave (
      output cfg_valid, cfg_count, cfg_incr, out_ready,
      input  cfg_ready, out_valid, out_incr, out_state, out_last
   );

endinterface

// File: rtl/swg_loop_cnt.sv
// -----------------------------------------------------------------------------
// swg_loop_cnt
// One loop level: down-counter that remembers its load value and reloads it
// when decremented at zero (the borrow case).
//   clk, rst_n   : clock, async active-low reset
//   i_load       : load i_load_val as both count and reload value
//   i_dec        : decrement (or reload when already zero)
//   o_zero       : current count is zero
//   o_next       : value the counter takes at the next edge
// -----------------------------------------------------------------------------
module swg_loop_cnt #(
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load,
   input  logic [CNT_BITS-1:0] i_load_val,
   input  logic                i_dec,
   output logic                o_zero,
   output logic [CNT_BITS-1:0] o_next
);

   logic [CNT_BITS-1:0] r_cnt;
   logic [CNT_BITS-1:0] r_reload;

   assign o_zero = (r_cnt == '0);

   // o_next is exported so the parent can see the post-step value one cycle
   // early and flag the last step on the same edge it presents it.
   always_comb begin
      o_next = r_cnt;
      if (i_load)     o_next = i_load_val;
      else if (i_dec) o_next = o_zero ? r_reload : r_cnt - CNT_BITS'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_reload <= '0;
      end else begin
         r_cnt <= o_next;
         if (i_load) r_reload <= i_load_val;
      end
   end

endmodule

// File: rtl/swg_loop_ctrl.sv
// -----------------------------------------------------------------------------
// swg_loop_ctrl
// Runtime-configured five-level loop walker for the sliding window generator.
// A config handshake loads counts/increments; the block then emits one tagged
// address increment per step (START first, then the tag of the outermost level
// that advanced) until H*W*KH*KW*SIMD steps are out, flagging the last one.
//   ap_clk, ap_rst_n : clock, async active-low reset (release must already be
//                      synchronous to ap_clk; the shell's reset bridge does it)
//   bus (master)     : cfg_* in, out_* stream out
// Parameters: CNT_BITS, INCR_BITS, IS_DEPTHWISE (0: SIMD innermost,
//             1: KW, KH, SIMD innermost-first).
// -----------------------------------------------------------------------------
module swg_loop_ctrl
   import swg_loop_ctrl_pkg::*;
#(
   parameter int CNT_BITS     = 16,
   parameter int INCR_BITS    = 16,
   parameter int IS_DEPTHWISE = 0
) (
   input  logic            ap_clk,
   input  logic            ap_rst_n,
   swg_loop_ctrl_if.master bus
);

   ctrl_e                           r_state, w_state_nxt;
   logic                            w_load, w_hs_out, w_step;
   logic                            w_cfg_single, w_next_all_zero;
   logic [LEVELS-1:0]               w_dec, w_zero;
   logic [LEVELS-1:0][CNT_BITS-1:0] w_ld_val, w_next;
   logic [2:0]                      w_tag;
   logic [6*INCR_BITS-1:0]          r_incr;
   state_e                          r_out_state;
   logic [INCR_BITS-1:0]            r_out_incr;
   logic                            r_out_last;

   // Handshake flags come straight from the state flop so that reset drops
   // out_valid and raises cfg_ready without waiting for a clock.
   assign bus.cfg_ready = (r_state == CTRL_IDLE);
   assign bus.out_valid = (r_state == CTRL_RUN);
   assign bus.out_incr  = r_out_incr;
   assign bus.out_state = r_out_state;
   assign bus.out_last  = r_out_last;

   assign w_hs_out = bus.out_valid && bus.out_ready;
   assign w_step   = w_hs_out && !r_out_last;

   // ---------------- FSM ----------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= CTRL_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         CTRL_IDLE: begin
            if (bus.cfg_valid) begin
               w_load      = 1'b1;
               w_state_nxt = CTRL_RUN;
            end
         end
         CTRL_RUN: begin
            if (w_hs_out && r_out_last) w_state_nxt = CTRL_IDLE;
         end
         default: w_state_nxt = CTRL_IDLE;
      endcase
   end

   // ---------------- config decode ----------------
   // A zero count behaves as one iteration, so both load the counter with 0.
   always_comb begin
      logic [CNT_BITS-1:0] v_cnt;
      v_cnt        = '0;
      w_cfg_single = 1'b1;
      for (int l = 0; l < LEVELS; l++) begin
         v_cnt       = bus.cfg_count[l*CNT_BITS +: CNT_BITS];
         w_ld_val[l] = (v_cnt == '0) ? '0 : v_cnt - CNT_BITS'(1);
         if (v_cnt > CNT_BITS'(1)) w_cfg_single = 1'b0;
      end
   end

   // ---------------- level counters ----------------
   for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
      swg_loop_cnt #(
         .CNT_BITS (CNT_BITS)
      ) u_cnt (
         .clk        (ap_clk),
         .rst_n      (ap_rst_n),
         .i_load     (w_load),
         .i_load_val (w_ld_val[g]),
         .i_dec      (w_dec[g]),
         .o_zero     (w_zero[g]),
         .o_next     (w_next[g])
      );
   end

   // ---------------- borrow chain ----------------
   // Walk innermost to outermost: a level decrements while the borrow is live;
   // the borrow only continues past levels sitting at zero. Exactly one level
   // decrements without wrapping on a non-last step, and that is the tag.
   always_comb begin
      logic v_borrow;
      int   v_lvl;
      v_borrow = w_step;
      v_lvl    = 0;
      w_dec    = '0;
      w_tag    = '0;
      for (int p = 0; p < LEVELS; p++) begin
         v_lvl        = order_lvl(IS_DEPTHWISE != 0, p);
         w_dec[v_lvl] = v_borrow;
         if (v_borrow && !w_zero[v_lvl]) w_tag = 3'(v_lvl);
         v_borrow     = v_borrow && w_zero[v_lvl];
      end
   end

   assign w_next_all_zero = (w_next == '0);

   // ---------------- step outputs ----------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_incr      <= '0;
         r_out_state <= STATE_START;
         r_out_incr  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_incr      <= bus.cfg_incr;
         r_out_state <= STATE_START;
         r_out_incr  <= bus.cfg_incr[INCR_BITS-1:0];
         r_out_last  <= w_cfg_single;
      end else if (w_step) begin
         r_out_state <= lvl2state(int'(w_tag));
         r_out_incr  <= r_incr[(int'(w_tag) + 1)*INCR_BITS +: INCR_BITS];
         r_out_last  <= w_next_all_zero;
      end
   end

endmodule

// File: doc/swg_loop_ctrl.md
Name: swg_loop_ctrl

Overview:
- Parametrised, runtime-configurable nested-loop controller for the sliding window generator (SWG).
- Walks the five loop levels H > W > KH > KW > SIMD. Emits one tagged address increment per step over a valid/ready stream; this stream drives the SWG buffer read-address datapath.
- Generalises the fixed loop sequencer in two ways:
  - loop bounds and per-level increments are loaded per image through a config handshake;
  - a depthwise mode reorders the innermost loops.

Parameters:
- CNT_BITS, 16, width of each loop-count field.
- INCR_BITS, 16, width of each signed increment field.
- IS_DEPTHWISE, 0, 0 = standard order (SIMD innermost); 1 = depthwise order (KW innermost, then KH, then SIMD).

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
- cfg_count  in  5*CNT_BITS  iteration counts {H,W,KH,KW,SIMD} (H in MSBs), unsigned
- cfg_incr  in  6*INCR_BITS  signed increments {H,W,KH,KW,SIMD,START} (H in MSBs)
- out_valid  out  1  step available
- out_ready  in  1  consumer accepts step
- out_incr  out  INCR_BITS  signed increment for this step
- out_state  out  3  swg::state_e tag of this step
- out_last  out  1  final step of the configured run

Behaviour:
- Reset (async assert, sync deassert into ap_clk domain):
  - enter IDLE; cfg_ready=1; out_valid=0; out_incr=0; out_state=STATE_START; out_last=0.
  - Reset mid-run aborts the run immediately; no partial state survives.
- IDLE:
  - cfg_ready=1; out_valid=0.
  - On a cfg handshake, latch all fields. A count of 0 is treated as 1.
  - Load each level counter with count-1.
  - Next cycle: out_valid=1, out_state=STATE_START, out_incr=incr_START, out_last = (all counts == 1). Enter RUN.
- RUN:
  - cfg_ready=0; cfg_valid is ignored.
  - Outputs stay stable while out_valid && !out_ready.
  - On an out handshake with !out_last, advance the counters by one odometer step in the active order.
    - Decrement the innermost level. If it is 0, reload it and borrow from the next level outward, and so on.
    - The outermost level that decrements without wrapping is the step tag.
    - Present on the next cycle: out_state = that level's enum (e.g. STATE_LOOP_KW), out_incr = that level's increment.
    - Throughput: 1 step/cycle with out_ready held high; zero bubbles.
  - out_last=1 on the presented step when every counter (after the step) is 0.
  - On an out handshake with out_last=1: next cycle out_valid=0, cfg_ready=1, IDLE.
    - Back-to-back runs therefore have exactly one idle cycle between the last step and the next START.
- Totals: exactly P = H*W*KH*KW*SIMD steps per run, one START followed by P-1 loop-tagged steps.
- Arithmetic:
  - Counters are CNT_BITS unsigned.
  - Increments are passed through unmodified; no sign extension or summation inside the block.
- Level order is fixed at elaboration by IS_DEPTHWISE; no runtime mode switch.

Decomposition:
- swg package: keep state_e unchanged. Add:
  - LEVELS=5 constant;
  - level-index localparams H=4, W=3, KH=2, KW=1, SIMD=0 for field slicing;
  - a function mapping level index to state_e.
- One sub-module: swg_loop_cnt, a single-level down-counter with load, dec, is_zero and wrap-reload. Instantiate it LEVELS times.
- Top-level holds the IDLE/RUN FSM and the order-dependent borrow chain.

Test Plan:
- All counts 1, START incr=7 -> single step (START, 7, last=1); cfg_ready returns 1 one cycle after the handshake.
- Standard order, counts H=1 W=1 KH=1 KW=2 SIMD=2, incr SIMD=1 KW=5 START=0 -> tags START, SIMD, KW, SIMD with incr 0,1,5,1; last only on the 4th step.
- IS_DEPTHWISE=1, same config, incr KH=9 -> tags START, KW, SIMD, KW; incr 0,5,1,5.
- Standard order, H=2 W=3 KH=3 KW=3 SIMD=4 with random out_ready -> 216 steps; outputs stable under stall; exactly 1 H-tag, 4 W-tags; compare against a reference odometer model.
- Count field = 0 on KW -> identical output to KW=1; cfg_valid asserted during RUN -> ignored, cfg_ready stays 0.
- ap_rst_n low on the 10th step of a run -> out_valid=0 and cfg_ready=1 asynchronously; a fresh config then starts cleanly with START.
